// File: rtl/pkg_frame_pkg.sv
// Shared types and constants for the package frame scheduler.
package pkg_frame_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ARB       = 3'd1,
        HDR       = 3'd2,
        PAY       = 3'd3,
        TRL       = 3'd4,
        WAIT_DONE = 3'd5
    } state_t;

    localparam logic [15:0] SYNC_WORD = 16'hEB90;
    localparam int          LEN_W     = 20;

    // Position of each word within the 4-word header
    localparam logic [1:0] HDR_W_SYNC = 2'd0;
    localparam logic [1:0] HDR_W_ID   = 2'd1;
    localparam logic [1:0] HDR_W_LENH = 2'd2;
    localparam logic [1:0] HDR_W_LENL = 2'd3;

endpackage

// File: rtl/pkg_rr_arb.sv
// Combinational round-robin arbiter: first requester at or after ptr, modulo NCH.
module pkg_rr_arb #(
    parameter int NCH = 4,
    parameter int IW  = $clog2(NCH)
) (
    input  logic [NCH-1:0] req,
    input  logic [IW-1:0]  ptr,
    output logic [NCH-1:0] gnt,
    output logic [IW-1:0]  idx,
    output logic           any
);

    // Scan from the farthest candidate down so the nearest one to ptr wins
    always_comb begin
        gnt = '0;
        idx = '0;
        any = |req;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % NCH]) begin
                gnt = '0;
                gnt[(int'(ptr) + k) % NCH] = 1'b1;
                idx = IW'((int'(ptr) + k) % NCH);
            end
        end
    end

endmodule

// File: rtl/pkg_frame_sched.sv
// Package frame scheduler: arbitrate channels, emit header + payload (+ checksum), await ack.
// Optional checksum trailer enabled by defining PKG_CSUM_EN.
module pkg_frame_sched #(
    parameter int          NCH       = 4,
    parameter logic [15:0] SYNC_WORD = pkg_frame_pkg::SYNC_WORD
) (
    input  logic                               clk_sys,
    input  logic                               rst,
    input  logic                               pluse_us,
    input  logic [5:0]                         dev_id,
    input  logic                               cfg_en,
    input  logic [15:0]                        cfg_tmo_us,
    input  logic [NCH-1:0]                     ch_req,
    input  logic [NCH*pkg_frame_pkg::LEN_W-1:0] ch_len,
    output logic [NCH-1:0]                     ch_gnt,
    input  logic [15:0]                        buf_q,
    input  logic                               buf_empty,
    output logic                               buf_rdreq,
    output logic [15:0]                        pkg_d,
    output logic                               pkg_vld,
    input  logic                               pkg_done,
    output logic                               busy,
    output logic                               err_tmo,
    output logic [15:0]                        pkg_cnt
);
    import pkg_frame_pkg::*;

    localparam int IW = $clog2(NCH);

    state_t             state, state_nxt, after_pay;
    logic [1:0]         hdr_cnt;
    logic [LEN_W-1:0]   len_r, req_rem, recv_rem, arb_len;
    logic [IW-1:0]      idx_r, ptr, arb_idx;
    logic [NCH-1:0]     gnt_r, arb_gnt;
    logic               arb_any, rd_pend, tmo, pay_word, in_wait;
    logic [15:0]        us_cnt;

`ifdef PKG_CSUM_EN
    logic [15:0] csum;
    assign after_pay = TRL;
`else
    assign after_pay = WAIT_DONE;
`endif

    pkg_rr_arb #(.NCH(NCH), .IW(IW)) u_arb (
        .req (ch_req),
        .ptr (ptr),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    assign arb_len   = ch_len[int'(arb_idx)*LEN_W +: LEN_W];
    assign in_wait   = (state == PAY) || (state == WAIT_DONE);
    assign tmo       = in_wait && (cfg_tmo_us != 16'd0) && (us_cnt >= cfg_tmo_us);
    assign pay_word  = (state == PAY) && rd_pend && !tmo;
    assign buf_rdreq = (state == PAY) && !buf_empty && (req_rem != '0) && !tmo;
    assign busy      = (state != IDLE);
    assign ch_gnt    = gnt_r;
    // A completing acknowledge wins over a timeout reached in the same cycle
    assign err_tmo   = tmo && !((state == WAIT_DONE) && pkg_done);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (cfg_en && |ch_req) state_nxt = ARB;
            ARB:       state_nxt = arb_any ? HDR : IDLE;
            HDR:       if (hdr_cnt == HDR_W_LENL) state_nxt = (len_r == '0) ? after_pay : PAY;
            PAY: begin
                if (tmo)                                          state_nxt = IDLE;
                else if (pay_word && (recv_rem == LEN_W'(1)))     state_nxt = after_pay;
            end
            TRL:       state_nxt = WAIT_DONE;
            WAIT_DONE: if (pkg_done || tmo) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pkg_vld = 1'b0;
        pkg_d   = '0;
        case (state)
            HDR: begin
                pkg_vld = 1'b1;
                case (hdr_cnt)
                    HDR_W_SYNC: pkg_d = SYNC_WORD;
                    HDR_W_ID:   pkg_d = {dev_id, 7'(idx_r), 3'b000};
                    HDR_W_LENH: pkg_d = {12'h000, len_r[19:16]};
                    default:    pkg_d = len_r[15:0];
                endcase
            end
            PAY: begin
                if (pay_word) begin
                    pkg_vld = 1'b1;
                    pkg_d   = buf_q;
                end
            end
`ifdef PKG_CSUM_EN
            TRL: begin
                pkg_vld = 1'b1;
                pkg_d   = csum;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            hdr_cnt  <= '0;
            len_r    <= '0;
            req_rem  <= '0;
            recv_rem <= '0;
            idx_r    <= '0;
            ptr      <= '0;
            gnt_r    <= '0;
            rd_pend  <= 1'b0;
            us_cnt   <= '0;
            pkg_cnt  <= '0;
        end else begin
            state   <= state_nxt;
            hdr_cnt <= (state == HDR) ? hdr_cnt + 2'd1 : 2'd0;
            rd_pend <= buf_rdreq;
            if (buf_rdreq) req_rem  <= req_rem - LEN_W'(1);
            if (pay_word)  recv_rem <= recv_rem - LEN_W'(1);
            if ((state == ARB) && arb_any) begin
                idx_r    <= arb_idx;
                len_r    <= arb_len;
                req_rem  <= arb_len;
                recv_rem <= arb_len;
                gnt_r    <= arb_gnt;
                ptr      <= (int'(arb_idx) == NCH - 1) ? '0 : arb_idx + IW'(1);
            end else if (state_nxt == IDLE) begin
                gnt_r <= '0;
            end
            if ((state == WAIT_DONE) && pkg_done) pkg_cnt <= pkg_cnt + 16'd1;
            // Stall timer restarts on any state change or delivered payload word
            if ((state_nxt != state) || pay_word)
                us_cnt <= '0;
            else if (pluse_us && in_wait && (us_cnt != 16'hFFFF))
                us_cnt <= us_cnt + 16'd1;
        end
    end

`ifdef PKG_CSUM_EN
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst)                         csum <= '0;
        else if (state == ARB)           csum <= '0;
        else if (pay_word)               csum <= csum + buf_q;
    end
`endif

endmodule

// File: doc/pkg_frame_sched.md
Name: pkg_frame_sched

Overview:
- Sequences the package datapath: round-robin arbitrates chip channels requesting to send, then grants one.
- Emits a 4-word header on pkg_d/pkg_vld, drains the granted payload from the chip buffer, and optionally appends a checksum.
- Waits for the downstream pkg_done acknowledge before the next grant.
- Sits between the chip-path buffer and the package output, inside the package top level.

Parameters:
- NCH, 4, number of chip channels (2..8).
- SYNC_WORD, 16'hEB90, header word 0.

Ports:
- clk_sys  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- pluse_us  in  1  one-cycle pulse every microsecond.
- dev_id  in  6  device id placed in the header.
- cfg_en  in  1  enables new grants.
- cfg_tmo_us  in  16  stall timeout in us; 0 disables the timeout.
- ch_req  in  NCH  per-channel send request (level).
- ch_len  in  NCH*20  per-channel payload length in 16-bit words; channel i at [20i+19:20i].
- ch_gnt  out  NCH  one-hot grant.
- buf_q  in  16  buffer read data, valid one cycle after buf_rdreq.
- buf_empty  in  1  buffer empty.
- buf_rdreq  out  1  buffer read request.
- pkg_d  out  16  package word.
- pkg_vld  out  1  pkg_d valid, one cycle per word.
- pkg_done  in  1  downstream acknowledge pulse.
- busy  out  1  high in every state except IDLE.
- err_tmo  out  1  one-cycle pulse on timeout abort.
- pkg_cnt  out  16  completed-package counter, wraps.

Behaviour:
- Reset values: all outputs 0, state IDLE, round-robin pointer 0.
- IDLE: if cfg_en and any ch_req, go to ARB.
  - cfg_en low blocks new grants only; a package in progress completes.
- ARB (1 cycle): pick the first requesting channel at or after the pointer, modulo NCH.
  - Latch its index and ch_len into len_r.
  - Assert ch_gnt for that channel; the grant holds until return to IDLE.
  - Set the pointer to index+1 mod NCH.
  - Go to HDR.
  - If ch_req dropped in the meantime, return to IDLE with no grant.
- HDR: 4 consecutive cycles with pkg_vld=1:
  - W0 = SYNC_WORD
  - W1 = {dev_id, 7'(index), 3'b000}
  - W2 = {12'h000, len_r[19:16]}
  - W3 = len_r[15:0]
  - Then go to PAY; if len_r==0, skip to TRL (or WAIT_DONE).
- PAY:
  - buf_rdreq=1 whenever !buf_empty and the remaining request count is >0.
  - The rdreq count equals len_r exactly.
  - Each returned word appears on pkg_d with pkg_vld=1 one cycle after its rdreq (1-cycle latency).
  - Leave PAY after the last data word is emitted.
- TRL: exists only with the optional feature (see below).
- WAIT_DONE: hold until pkg_done.
  - On pkg_done: increment pkg_cnt, drop ch_gnt, go to IDLE.
  - pkg_done in any other state is ignored.
  - pkg_done and a new ch_req in the same cycle: the new grant happens no earlier than the next ARB.
- Timeout:
  - The us counter clears on every state entry and on every emitted payload word.
  - It increments on pluse_us while in PAY or WAIT_DONE.
  - When it reaches cfg_tmo_us (nonzero): pulse err_tmo, stop buf_rdreq, discard any in-flight read, drop ch_gnt, go to IDLE. pkg_cnt does not increment.
- Width rules:
  - Remaining count is 20-bit unsigned.
  - The us counter is 16-bit and saturates.
  - Checksum is a 16-bit sum mod 2^16.
- Async reset mid-package: immediate return to reset values; no partial trailer is emitted.

Optional Feature:
- Macro: PKG_CSUM_EN.
- Defined: a TRL state follows PAY (or HDR when len_r==0).
  - TRL emits one word, the mod-2^16 sum of all payload words (0 when len=0), with pkg_vld=1.
  - Then go to WAIT_DONE.
- Undefined: no TRL state; PAY goes directly to WAIT_DONE, and no accumulator is synthesized.

Decomposition:
- Package pkg_frame_pkg holds:
  - state encoding constants (IDLE, ARB, HDR, PAY, TRL, WAIT_DONE)
  - SYNC_WORD
  - header word index constants
  - LEN_W=20
- One sub-module, pkg_rr_arb: NCH-wide round-robin arbiter.
  - Inputs: req vector, pointer.
  - Outputs: one-hot grant and index; combinational.

Test Plan:
- Single channel, len=3, buffer always ready:
  - pkg_d = EB90, {dev_id,idx,000}, 0000, 0003, then d0, d1, d2.
  - Exactly 3 rdreqs.
  - pkg_cnt 0→1 on pkg_done.
- ch_req=4'b1111 held, 4 packages each acknowledged: grants in order ch0, ch1, ch2, ch3.
  - After pointer=2, requests on ch0+ch3 → ch3 granted.
- len=0 with PKG_CSUM_EN: 4 header words plus trailer 0000; no rdreq.
  - Without the macro: header only.
- Payload 0xFFFF, 0x0002 with PKG_CSUM_EN: trailer = 0x0001 (wrap).
- cfg_tmo_us=2, buffer empty after 1 of 4 words: err_tmo pulses after 2 pluse_us, grant drops, state IDLE, pkg_cnt unchanged.
- Async rst asserted mid-PAY: all outputs 0 the same cycle.
  - After release, a new request is granted starting from pointer 0.
